// File: rtl/mux_rr_8.sv
// mux_rr_8 : eight-channel round-robin multiplexer with a one-entry output register.
//
// Each cycle the arbiter searches the channels with in_valid high, starting at the
// round-robin pointer and wrapping 7 -> 0, and grants the first one it finds. The
// granted word is captured into the output register together with its channel
// index. The pointer then moves to the channel after the winner, so every
// requester is served within seven other grants.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_data    : eight channel words, channel i at [i*DATA_W +: DATA_W]
//   in_valid   : per-channel valid
//   in_ready   : per-channel accept, one-hot or zero, combinational
//   out_data   : registered multiplexed word
//   out_sel    : index of the channel that supplied out_data
//   out_valid  : out_data/out_sel hold a word
//   out_ready  : downstream accept
module mux_rr_8 #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*DATA_W-1:0]   in_data,
    input  logic [7:0]            in_valid,
    output logic [7:0]            in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [2:0]        ptr_q;
    logic [2:0]        ptr_d;
    logic [DATA_W-1:0] outData_q;
    logic [DATA_W-1:0] outData_d;
    logic [2:0]        outSel_q;
    logic [2:0]        outSel_d;
    logic              outValid_q;
    logic              outValid_d;

    logic              load;
    logic              found;
    logic [2:0]        grantIdx;
    logic              doGrant;

    // The output register can take a new word when it is empty or being drained.
    assign load = !outValid_q || out_ready;

    // Search upward from the pointer; the 3-bit sum wraps naturally from 7 to 0,
    // so the first hit is the round-robin winner.
    always_comb begin
        found    = 1'b0;
        grantIdx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!found && in_valid[ptr_q + 3'(k)]) begin
                found    = 1'b1;
                grantIdx = ptr_q + 3'(k);
            end
        end
    end

    // Reset blocks the grant so no word is consumed while state is being cleared.
    assign doGrant  = load && found && !rst;
    assign in_ready = doGrant ? (8'b0000_0001 << grantIdx) : 8'b0000_0000;

    // Next-state: a grant loads the register and advances the pointer past the
    // winner; an idle load empties the register but keeps data, index and pointer;
    // a stall (no load) holds everything.
    always_comb begin
        ptr_d      = ptr_q;
        outData_d  = outData_q;
        outSel_d   = outSel_q;
        outValid_d = outValid_q;
        if (load) begin
            if (found) begin
                outData_d  = in_data[32'(grantIdx) * DATA_W +: DATA_W];
                outSel_d   = grantIdx;
                outValid_d = 1'b1;
                ptr_d      = grantIdx + 3'd1;
            end else begin
                outValid_d = 1'b0;
            end
        end
    end

    // Reset discards any held word, accepted downstream or not, and restarts
    // arbitration at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 3'd0;
            outData_q  <= '0;
            outSel_q   <= 3'd0;
            outValid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            outData_q  <= outData_d;
            outSel_q   <= outSel_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_data  = outData_q;
    assign out_sel   = outSel_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_mux_rr_8.sv
// tb_mux_rr_8 : directed bench for mux_rr_8 (DATA_W = 8).
//
// A table of per-cycle records gives the inputs for one cycle, the in_ready
// expected before the edge and the registered outputs expected after it. Rows run
// in order, so the table also encodes pointer history. A hand-written sequence
// afterwards covers a stall with changing input data.
module tb_mux_rr_8;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst;
    logic [8*DATA_W-1:0] inData;
    logic [7:0]          inValid;
    logic [7:0]          inReady;
    logic [DATA_W-1:0]   outData;
    logic [2:0]          outSel;
    logic                outValid;
    logic                outReady;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst;
        logic [7:0]  valid;
        logic [63:0] data;
        logic        oReady;
        logic [7:0]  expInReady;
        logic        expOutValid;
        logic [2:0]  expOutSel;
        logic [7:0]  expOutData;
    } vec_t;

    vec_t vecs[$];

    mux_rr_8 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_data  (outData),
        .out_sel   (outSel),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and report any difference.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge.
    task automatic applyStimulus(input logic r, input logic [7:0] v, input logic [63:0] d, input logic ordy);
        @(negedge clk);
        rst      = r;
        inValid  = v;
        inData   = d;
        outReady = ordy;
    endtask

    task automatic addVec(input logic r, input logic [7:0] v, input logic [63:0] d, input logic ordy,
                          input logic [7:0] eInR, input logic eOv, input logic [2:0] eSel, input logic [7:0] eData);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.oReady = ordy;
        x.expInReady = eInR; x.expOutValid = eOv; x.expOutSel = eSel; x.expOutData = eData;
        vecs.push_back(x);
    endtask

    localparam logic [63:0] D   = 64'h1716151413121110;
    localparam logic [63:0] D5  = 64'h0000A50000000000;
    localparam logic [63:0] DX  = 64'h0123456789ABCDEF;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        inValid    = 8'hFF;
        inData     = D;
        outReady   = 1'b1;

        // Reset held two cycles with every channel requesting.
        addVec(1, 8'hFF, D, 1, 8'h00, 0, 3'd0, 8'h00);
        addVec(1, 8'hFF, D, 1, 8'h00, 0, 3'd0, 8'h00);
        // Single request on channel 5, then idle (data/index retained).
        addVec(0, 8'h20, D5, 1, 8'h20, 1, 3'd5, 8'hA5);
        addVec(0, 8'h00, D5, 1, 8'h00, 0, 3'd5, 8'hA5);
        // Reset again so the full sweep starts from channel 0.
        addVec(1, 8'h00, D, 1, 8'h00, 0, 3'd0, 8'h00);
        // All channels valid for nine cycles: 0..7 then 0, no bubbles.
        for (int k = 0; k < 9; k++) begin
            addVec(0, 8'hFF, D, 1, 8'h01 << (k % 8), 1, 3'(k % 8), 8'h10 + 8'(k % 8));
        end
        // Grant channel 3, stall four cycles, then release; pointer 4 resumes.
        addVec(0, 8'h08, D, 1, 8'h08, 1, 3'd3, 8'h13);
        for (int k = 0; k < 4; k++) begin
            addVec(0, 8'hFF, D, 0, 8'h00, 1, 3'd3, 8'h13);
        end
        addVec(0, 8'hFF, D, 1, 8'h10, 1, 3'd4, 8'h14);
        // Grant 7, then 0 and 6 both valid: wrap to 0 first, then 6.
        addVec(0, 8'h80, D, 1, 8'h80, 1, 3'd7, 8'h17);
        addVec(0, 8'h41, D, 1, 8'h01, 1, 3'd0, 8'h10);
        addVec(0, 8'h41, D, 1, 8'h40, 1, 3'd6, 8'h16);
        // Pointer at 7 with 1 and 2 valid: wrap finds 1.
        addVec(0, 8'h06, D, 1, 8'h02, 1, 3'd1, 8'h11);
        // Hold word, reset mid-stall, then search restarts from channel 0.
        addVec(0, 8'h00, D, 0, 8'h00, 1, 3'd1, 8'h11);
        addVec(1, 8'hFF, D, 0, 8'h00, 0, 3'd0, 8'h00);
        addVec(0, 8'h0C, D, 0, 8'h04, 1, 3'd2, 8'h12);
        addVec(0, 8'h0C, D, 0, 8'h00, 1, 3'd2, 8'h12);
        addVec(0, 8'h00, D, 1, 8'h00, 0, 3'd2, 8'h12);
        // Distinct data pattern to exercise the word slice (ptr 3 -> channel 4).
        addVec(0, 8'h10, DX, 1, 8'h10, 1, 3'd4, 8'h67);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].oReady);
            #1;
            checkOutput($sformatf("in_ready[%0d]", i), 64'(inReady), 64'(vecs[i].expInReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("out_valid[%0d]", i), 64'(outValid), 64'(vecs[i].expOutValid));
            checkOutput($sformatf("out_sel[%0d]", i), 64'(outSel), 64'(vecs[i].expOutSel));
            checkOutput($sformatf("out_data[%0d]", i), 64'(outData), 64'(vecs[i].expOutData));
        end

        // Stall sequence: the held word must not follow in_data while out_ready=0.
        // Pointer is 5 here; channel 2 is the only requester.
        applyStimulus(0, 8'h04, 64'h00000000005A0000, 1);
        @(posedge clk); #1;
        checkOutput("seq_load_data", 64'(outData), 64'h5A);
        checkOutput("seq_load_sel", 64'(outSel), 64'd2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 8'hFF, 64'(k) * 64'h1111111111111111 + 64'h0F0F0F0F0F0F0F0F, 0);
            #1;
            checkOutput("seq_stall_in_ready", 64'(inReady), 64'h00);
            @(posedge clk); #1;
            checkOutput("seq_stall_data", 64'(outData), 64'h5A);
            checkOutput("seq_stall_valid", 64'(outValid), 64'd1);
        end
        // Release with channel 3 alone valid: pointer 3 grants it at once.
        applyStimulus(0, 8'h08, 64'h00000000C3000000, 1);
        #1;
        checkOutput("seq_release_in_ready", 64'(inReady), 64'h08);
        @(posedge clk); #1;
        checkOutput("seq_release_data", 64'(outData), 64'hC3);
        checkOutput("seq_release_sel", 64'(outSel), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_rr_8.md
MUX_RR_8 -- requirements
Module: mux_rr_8

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the width of each channel's data word.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_data, input, 8*DATA_W, the eight channel words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-005 SHALL have port in_valid, input, 8, per-channel valid; bit i means channel i offers a word.
REQ-006 SHALL have port in_ready, output, 8, per-channel accept; at most one bit is high in any cycle.
REQ-007 SHALL have port out_data, output, DATA_W, the registered multiplexed word.
REQ-008 SHALL have port out_sel, output, 3, the index of the channel that supplied out_data.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data and out_sel hold a word.
REQ-010 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-011 SHALL transfer a word on channel i only in a cycle where in_valid[i] and in_ready[i] are both 1, and SHALL deliver on the output only in a cycle where out_valid and out_ready are both 1.
REQ-012 SHALL define load = !out_valid || out_ready, meaning the output register is empty or is being drained this cycle.
REQ-013 SHALL hold a 3-bit round-robin pointer ptr and SHALL grant the first channel with in_valid high, searching from index ptr upward and wrapping 7 to 0.
REQ-014 SHALL drive in_ready combinationally as the one-hot grant when load=1 and at least one in_valid is high; otherwise in_ready=8'b0. in_ready may depend on in_valid in the same cycle.
REQ-015 SHALL, on a granted transfer from channel g, register out_data=in_data[g], out_sel=g and out_valid=1 at the next edge; input-to-output latency is exactly 1 cycle.
REQ-016 SHALL, on a granted transfer, set ptr=g+1 modulo 8; the value after g=7 is 0.
REQ-017 SHALL, when load=1 and no in_valid is high, set out_valid=0 at the next edge and leave ptr, out_data and out_sel unchanged.
REQ-018 SHALL, while out_valid=1 and out_ready=0, hold out_data, out_sel, out_valid and ptr stable and keep in_ready=8'b0.
REQ-019 SHALL sustain one word per cycle when out_ready is held at 1 and inputs are continuously valid, with no bubble cycles.
REQ-020 SHALL ensure no channel waits more than 7 other grants while its in_valid stays high.
REQ-021 SHALL neither drop nor duplicate a word: every input handshake produces exactly one output handshake carrying the same data and channel index.

Reset
REQ-022 SHALL, on a clk edge with rst=1, set out_valid=0, out_data=0, out_sel=0 and ptr=0.
REQ-023 SHALL force in_ready=8'b0 while rst=1.
REQ-024 SHALL discard any word held in the output register when reset is asserted mid-stream, whether or not it was accepted downstream.
REQ-025 SHALL behave as after a fresh reset in the first cycle after rst falls, starting arbitration from channel 0.

Verification
REQ-026 SHALL be verified by the following scenario. Stimulus: rst=1 for 2 cycles with all in_valid=1. Response: out_valid=0, out_sel=0, out_data=0, in_ready=8'b0 throughout.
REQ-027 SHALL be verified by the following scenario. Stimulus: after reset, only channel 5 valid with data 0xA5, out_ready=1. Response: in_ready=8'b0010_0000 in the same cycle; in the next cycle out_valid=1, out_data=0xA5, out_sel=5.
REQ-028 SHALL be verified by the following scenario. Stimulus: all 8 channels valid with data 0x10+i, out_ready=1, for 9 cycles. Response: out_sel runs 0,1,2,3,4,5,6,7,0 on consecutive cycles, with out_data=0x10+out_sel each cycle.
REQ-029 SHALL be verified by the following scenario. Stimulus: out_valid=1 with out_sel=3, then out_ready=0 for 4 cycles. Response: out_data and out_sel stay constant, in_ready=8'b0, ptr unchanged; the held word is delivered on the first cycle out_ready returns to 1.
REQ-030 SHALL be verified by the following scenario. Stimulus: after a grant to channel 7, channels 0 and 6 are valid. Response: channel 0 is granted next (wrap-around), then channel 6.
REQ-031 SHALL be verified by the following scenario. Stimulus: rst=1 for 1 cycle while out_valid=1 and out_ready=0. Response: out_valid=0 on the next cycle, the held word is never delivered, and the next grant searches from channel 0.
